// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt controller:
// CSR addresses, register bit positions, CSR opcodes and controller states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int IRQ_MT       = 7;
    localparam int IRQ_ME       = 11;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WFI  = 1'b1
    } csr_state_e;

    // Immediate and register forms share the same read-modify-write rule.
    function automatic logic [31:0] csr_apply(input logic [2:0] op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            OP_RW, OP_RWI: csr_apply = wdata;
            OP_RS, OP_RSI: csr_apply = old_val | wdata;
            OP_RC, OP_RCI: csr_apply = old_val & ~wdata;
            default:       csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_irq_ctrl_if.sv
// CSR access bus between the EX stage (master) and the CSR file (slave).
interface csr_irq_ctrl_if;
    logic        csr_en;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (output csr_en, csr_op, csr_addr, csr_wdata, input csr_rdata);
    modport slave  (input csr_en, csr_op, csr_addr, csr_wdata, output csr_rdata);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit word writes; a write
// in the same cycle takes precedence over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (wr_lo) begin
            count_reg[31:0] <= wdata;
        end else if (wr_hi) begin
            count_reg[63:32] <= wdata;
        end else if (inc) begin
            count_reg <= count_reg + 64'd1;
        end
    end

    assign value = count_reg;

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and interrupt controller: CSR read/modify/write,
// trap entry, MRET, WFI stall and the cycle/instret counters.
module csr_irq_ctrl
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0001_0000,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    csr_irq_ctrl_if.slave        csr,
    input  logic                 inst_mret,
    input  logic                 inst_wfi,
    input  logic [31:0]          ex_pc,
    input  logic                 inst_retire,
    input  logic                 ext_irq,
    input  logic                 timer_irq,
    input  logic                 im_stall,
    input  logic                 dm_stall,
    output logic                 CSR_interrupt,
    output logic [31:0]          CSR_ISR_pc,
    output logic                 CSR_ret,
    output logic [31:0]          CSR_retpc,
    output logic                 CSR_stall
);

    csr_state_e  state_reg;
    logic        mie_reg, mpie_reg, meie_reg, mtie_reg;
    logic [31:0] mtvec_reg, mepc_reg, wfi_pc_reg;
    logic [63:0] cnt_value [2];

    logic        pend, take, in_idle;
    logic        ret_fire, trap_fire, wfi_enter, csr_wr;
    logic [31:0] csr_new, trap_pc;

    assign pend     = (ext_irq & meie_reg) | (timer_irq & mtie_reg);
    assign take     = mie_reg & pend & ~im_stall & ~dm_stall;
    assign in_idle  = (state_reg == ST_IDLE);

    // Inside WFI the wake-up trap is not gated by memory stalls: the pipeline is parked.
    assign ret_fire  = reset & in_idle & inst_mret;
    assign trap_fire = reset & (in_idle ? (~inst_mret & take) : (pend & mie_reg));
    assign wfi_enter = reset & in_idle & ~inst_mret & ~take & inst_wfi & ~pend;
    assign trap_pc   = in_idle ? ex_pc : wfi_pc_reg;

    assign csr_new = csr_apply(csr.csr_op, csr.csr_rdata, csr.csr_wdata);
    assign csr_wr  = csr.csr_en & (csr.csr_op[1:0] != 2'b00) & ~trap_fire & ~ret_fire;

    assign CSR_interrupt = trap_fire;
    assign CSR_ret       = ret_fire;
    assign CSR_stall     = in_idle ? wfi_enter : (reset & ~pend);
    assign CSR_ISR_pc    = mtvec_reg;
    assign CSR_retpc     = mepc_reg;

    always_comb begin
        csr.csr_rdata = '0;
        case (csr.csr_addr)
            CSR_MSTATUS: begin
                csr.csr_rdata[12:11]        = 2'b11;
                csr.csr_rdata[MSTATUS_MIE]  = mie_reg;
                csr.csr_rdata[MSTATUS_MPIE] = mpie_reg;
            end
            CSR_MIE: begin
                csr.csr_rdata[IRQ_MT] = mtie_reg;
                csr.csr_rdata[IRQ_ME] = meie_reg;
            end
            CSR_MTVEC: csr.csr_rdata = mtvec_reg;
            CSR_MEPC:  csr.csr_rdata = mepc_reg;
            CSR_MIP: begin
                csr.csr_rdata[IRQ_MT] = timer_irq;
                csr.csr_rdata[IRQ_ME] = ext_irq;
            end
            CSR_MCYCLE,    CSR_CYCLE:    csr.csr_rdata = cnt_value[0][31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   csr.csr_rdata = cnt_value[0][63:32];
            CSR_MINSTRET,  CSR_INSTRET:  csr.csr_rdata = cnt_value[1][31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr.csr_rdata = cnt_value[1][63:32];
            default: csr.csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            mie_reg    <= 1'b0;
            mpie_reg   <= 1'b0;
            meie_reg   <= 1'b0;
            mtie_reg   <= 1'b0;
            mtvec_reg  <= {MTVEC_RESET[31:2], 2'b00};
            mepc_reg   <= '0;
            wfi_pc_reg <= '0;
        end else begin
            if (ret_fire) begin
                mie_reg  <= mpie_reg;
                mpie_reg <= 1'b1;
            end else if (trap_fire) begin
                mepc_reg <= {trap_pc[31:2], 2'b00};
                mpie_reg <= mie_reg;
                mie_reg  <= 1'b0;
            end else if (csr_wr) begin
                case (csr.csr_addr)
                    CSR_MSTATUS: begin
                        mie_reg  <= csr_new[MSTATUS_MIE];
                        mpie_reg <= csr_new[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mtie_reg <= csr_new[IRQ_MT];
                        meie_reg <= csr_new[IRQ_ME];
                    end
                    CSR_MTVEC: mtvec_reg <= {csr_new[31:2], 2'b00};
                    CSR_MEPC:  mepc_reg  <= {csr_new[31:2], 2'b00};
                    default: ;
                endcase
            end

            case (state_reg)
                ST_IDLE: begin
                    if (wfi_enter) begin
                        state_reg  <= ST_WFI;
                        wfi_pc_reg <= ex_pc + 32'd4;
                    end
                end
                ST_WFI: begin
                    if (pend) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Index 0 is mcycle (always counts), index 1 is minstret (counts on retire).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic [11:0] LO_ADDR = (gi == 0) ? CSR_MCYCLE  : CSR_MINSTRET;
            localparam logic [11:0] HI_ADDR = (gi == 0) ? CSR_MCYCLEH : CSR_MINSTRETH;
            if (HAS_COUNTERS) begin : g_on
                csr_counter64 u_cnt (
                    .clk   (clk),
                    .reset (reset),
                    .inc   ((gi == 0) ? 1'b1 : inst_retire),
                    .wr_lo (csr_wr && (csr.csr_addr == LO_ADDR)),
                    .wr_hi (csr_wr && (csr.csr_addr == HI_ADDR)),
                    .wdata (csr_new),
                    .value (cnt_value[gi])
                );
            end else begin : g_off
                assign cnt_value[gi] = '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Self-checking bench for csr_irq_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_csr_irq_ctrl;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_mret, inst_wfi, inst_retire;
    logic [31:0] ex_pc;
    logic        ext_irq, timer_irq, im_stall, dm_stall;
    logic        CSR_interrupt, CSR_ret, CSR_stall;
    logic [31:0] CSR_ISR_pc, CSR_retpc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_irq_ctrl_if bus ();

    csr_irq_ctrl #(
        .MTVEC_RESET  (32'h0001_0000),
        .HAS_COUNTERS (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .csr           (bus),
        .inst_mret     (inst_mret),
        .inst_wfi      (inst_wfi),
        .ex_pc         (ex_pc),
        .inst_retire   (inst_retire),
        .ext_irq       (ext_irq),
        .timer_irq     (timer_irq),
        .im_stall      (im_stall),
        .dm_stall      (dm_stall),
        .CSR_interrupt (CSR_interrupt),
        .CSR_ISR_pc    (CSR_ISR_pc),
        .CSR_ret       (CSR_ret),
        .CSR_retpc     (CSR_retpc),
        .CSR_stall     (CSR_stall)
    );

    // Behavioural model state
    bit          m_mie, m_mpie, m_meie, m_mtie, m_in_wfi;
    logic [31:0] m_mtvec, m_mepc, m_wfi_pc;
    logic [63:0] m_cyc, m_ins;

    bit [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123};

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: return (m_mtie ? 32'h80 : 32'h0) | (m_meie ? 32'h800 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h344: return (timer_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0; m_in_wfi = 0;
        m_mtvec = 32'h0001_0000; m_mepc = 0; m_wfi_pc = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string tag);
        bus.csr_addr = a;
        #1;
        chk(tag, bus.csr_rdata, exp);
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic step();
        bit pend, take, e_int, e_ret, e_stall, wr;
        logic [31:0] old_v, nv, w;
        logic [63:0] c, i;
        @(negedge clk);
        pend = (ext_irq && m_meie) || (timer_irq && m_mtie);
        take = m_mie && pend && !im_stall && !dm_stall;
        if (!reset) begin
            e_int = 0; e_ret = 0; e_stall = 0;
        end else if (m_in_wfi) begin
            e_int = pend && m_mie; e_ret = 0; e_stall = !pend;
        end else begin
            e_ret   = inst_mret;
            e_int   = !inst_mret && take;
            e_stall = !inst_mret && !take && inst_wfi && !pend;
        end
        chk("rdata", bus.csr_rdata, model_read(bus.csr_addr));
        chk("interrupt", {31'b0, CSR_interrupt}, {31'b0, e_int});
        chk("ret", {31'b0, CSR_ret}, {31'b0, e_ret});
        chk("stall", {31'b0, CSR_stall}, {31'b0, e_stall});
        chk("isr_pc", CSR_ISR_pc, m_mtvec);
        chk("retpc", CSR_retpc, m_mepc);
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            old_v = model_read(bus.csr_addr);
            w = bus.csr_wdata;
            case (bus.csr_op[1:0])
                2'b01:   nv = w;
                2'b10:   nv = old_v | w;
                2'b11:   nv = old_v & ~w;
                default: nv = old_v;
            endcase
            wr = bus.csr_en && (bus.csr_op[1:0] != 2'b00) && !e_int && !e_ret;
            c = m_cyc + 64'd1;
            i = m_ins + (inst_retire ? 64'd1 : 64'd0);
            if (e_ret) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (e_int) begin
                m_mepc = m_in_wfi ? m_wfi_pc : ex_pc;
                m_mpie = m_mie; m_mie = 0;
            end
            if (m_in_wfi) begin
                if (pend) m_in_wfi = 0;
            end else if (e_stall) begin
                m_in_wfi = 1; m_wfi_pc = ex_pc + 32'd4;
            end
            if (wr) begin
                case (bus.csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: begin m_mtie = nv[7]; m_meie = nv[11]; end
                    12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
                    12'h341: m_mepc  = nv & 32'hFFFF_FFFC;
                    12'hB00: c = {m_cyc[63:32], nv};
                    12'hB80: c = {nv, m_cyc[31:0]};
                    12'hB02: i = {m_ins[63:32], nv};
                    12'hB82: i = {nv, m_ins[31:0]};
                    default: ;
                endcase
            end
            m_cyc = c; m_ins = i;
        end
        #1;
    endtask

    task automatic csr_do(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_en = 1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
        step();
        bus.csr_en = 0;
    endtask

    initial begin
        reset = 0; inst_mret = 0; inst_wfi = 0; inst_retire = 0; ex_pc = 0;
        ext_irq = 0; timer_irq = 0; im_stall = 0; dm_stall = 0;
        bus.csr_en = 0; bus.csr_op = 3'b000; bus.csr_addr = 12'h300; bus.csr_wdata = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 reset = 1;

        // Reset values
        peek(12'h305, 32'h0001_0000, "rst_mtvec");
        peek(12'h300, 32'h0000_1800, "rst_mstatus");
        chk("rst_pulses", {29'b0, CSR_interrupt, CSR_ret, CSR_stall}, 32'h0);
        step();

        // Enable MIE and MEIE, then take an external interrupt
        csr_do(3'b010, 12'h300, 32'h8);
        csr_do(3'b010, 12'h304, 32'h800);
        ext_irq = 1; ex_pc = 32'h140; bus.csr_addr = 12'h300;
        #1;
        chk("trap_pulse", {31'b0, CSR_interrupt}, 32'h1);
        chk("trap_target", CSR_ISR_pc, 32'h0001_0000);
        step();
        chk("trap_once", {31'b0, CSR_interrupt}, 32'h0);
        peek(12'h341, 32'h140, "trap_mepc");
        peek(12'h300, 32'h0000_1880, "trap_mstatus");

        // MRET with the interrupt still asserted
        inst_mret = 1;
        #1;
        chk("mret_pulse", {31'b0, CSR_ret}, 32'h1);
        chk("mret_target", CSR_retpc, 32'h140);
        chk("mret_no_trap", {31'b0, CSR_interrupt}, 32'h0);
        step();
        inst_mret = 0;
        peek(12'h300, 32'h0000_1888, "mret_mstatus");
        chk("retrap_after_ret", {31'b0, CSR_interrupt}, 32'h1);
        step();
        ext_irq = 0;
        inst_mret = 1; step(); inst_mret = 0;

        // WFI with timer wake-up
        csr_do(3'b010, 12'h304, 32'h80);
        inst_wfi = 1; ex_pc = 32'h200;
        for (int k = 0; k < 10; k++) begin
            #1 chk("wfi_stall", {31'b0, CSR_stall}, 32'h1);
            step();
            inst_wfi = 0;
        end
        timer_irq = 1;
        #1;
        chk("wfi_wake_pulse", {31'b0, CSR_interrupt}, 32'h1);
        chk("wfi_wake_release", {31'b0, CSR_stall}, 32'h0);
        step();
        timer_irq = 0;
        peek(12'h341, 32'h204, "wfi_mepc");
        inst_mret = 1; step(); inst_mret = 0;

        // Memory stall holds off the trap; a CSR write in the trap cycle is dropped
        ext_irq = 1; dm_stall = 1; ex_pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            #1 chk("dmstall_hold", {31'b0, CSR_interrupt}, 32'h0);
            step();
        end
        dm_stall = 0;
        bus.csr_en = 1; bus.csr_op = 3'b001; bus.csr_addr = 12'h341; bus.csr_wdata = 32'h0000_ABC0;
        #1 chk("dmstall_release", {31'b0, CSR_interrupt}, 32'h1);
        step();
        bus.csr_en = 0; ext_irq = 0;
        peek(12'h341, 32'h300, "trap_drops_write");
        inst_mret = 1; step(); inst_mret = 0;

        // 64-bit counter carry across the word boundary
        csr_do(3'b001, 12'hB00, 32'hFFFF_FFFF);
        csr_do(3'b001, 12'hB80, 32'h0);
        step();
        peek(12'hC80, 32'h1, "cycleh_carry");
        peek(12'hC00, 32'h0, "cycle_wrap");

        // Reset while parked in WFI
        inst_wfi = 1; ex_pc = 32'h400; step(); inst_wfi = 0;
        step();
        reset = 0; step(); reset = 1;
        #1 chk("reset_aborts_wfi", {31'b0, CSR_stall}, 32'h0);
        peek(12'h300, 32'h0000_1800, "reset_mstatus");
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) != 0);
            inst_mret   = ($urandom_range(0, 19) == 0);
            inst_wfi    = ($urandom_range(0, 19) == 0);
            inst_retire = $urandom_range(0, 1);
            ex_pc       = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ext_irq   = ~ext_irq;
            if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
            im_stall    = ($urandom_range(0, 4) == 0);
            dm_stall    = ($urandom_range(0, 4) == 0);
            bus.csr_en    = ($urandom_range(0, 2) == 0);
            bus.csr_op    = 3'($urandom_range(0, 7));
            bus.csr_addr  = addrs[$urandom_range(0, 13)];
            bus.csr_wdata = $urandom();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
